// File: rtl/sort_xcel_pkg.sv
// Shared types and default sizing for the sorting accelerator's batch sort stage.
package sort_xcel_pkg;

  localparam int unsigned NCELLS_DEF = 4;
  localparam int unsigned W_DEF      = 32;

  typedef enum logic [1:0] {
    StLoad,
    StSort,
    StDrain
  } state_e;

endpackage

// File: rtl/sort_xcel_cell.sv
// One compare-and-swap cell: a 2:1 mux into an enabled register, plus a comparator
// against the currently selected swap partner.
module sort_xcel_cell
  import sort_xcel_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         sel,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  output logic [W-1:0] out,
  output logic         gt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
    end else if (en) begin
      out <= sel ? in1 : in0;
    end
  end

  assign gt = out > in1;

endmodule

// File: rtl/sort_xcel_batch.sv
// Batch sort stage: loads NCELLS words, sorts them by odd-even transposition in
// NCELLS phases, then streams them out ascending.
module sort_xcel_batch
  import sort_xcel_pkg::*;
#(
  parameter int unsigned NCELLS = NCELLS_DEF,
  parameter int unsigned W      = W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_val,
  output logic         in_rdy,
  input  logic [W-1:0] in_msg,
  output logic         out_val,
  input  logic         out_rdy,
  output logic [W-1:0] out_msg,
  output logic         out_last
);

  localparam int unsigned CW = $clog2(NCELLS + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            in_reset_q;

  logic [W-1:0]      r [NCELLS];
  logic [NCELLS-1:0] gt, swap, swap_dn, sel, en;
  logic              in_fire, out_fire, is_sort, phase_odd, cnt_last;
  logic [W-1:0]      shift_in;

  assign cnt_last  = (cnt_q == CW'(NCELLS - 1));
  assign is_sort   = (state_q == StSort);
  assign phase_odd = cnt_q[0];

  // in_reset_q keeps handshakes low during reset without a path from the reset pin.
  assign in_rdy   = (state_q == StLoad) && !in_reset_q;
  assign out_val  = (state_q == StDrain) && !in_reset_q;
  assign out_msg  = r[0];
  assign out_last = out_val && cnt_last;

  assign in_fire  = in_val && in_rdy;
  assign out_fire = out_val && out_rdy;

  // Loading feeds the tail from the input; draining keeps the tail in place.
  assign shift_in = (state_q == StLoad) ? in_msg : r[NCELLS-1];

  // A swap flagged at the lower cell of a pair also moves its upper neighbour.
  assign swap_dn = {swap[NCELLS-2:0], 1'b0};
  assign sel     = swap | swap_dn;
  assign en      = {NCELLS{in_fire || out_fire}} | sel;

  for (genvar i = 0; i < NCELLS; i++) begin : g_cell
    localparam logic IsOdd = ((i % 2) == 1);
    logic [W-1:0] shift_nb, up, dn, partner;

    if (i == NCELLS - 1) begin : g_tail
      assign shift_nb = shift_in;
      assign up       = r[i];
    end else begin : g_body
      assign shift_nb = r[i+1];
      assign up       = r[i+1];
    end

    if (i == 0) begin : g_head
      assign dn = r[i];
    end else begin : g_rest
      assign dn = r[i-1];
    end

    // A cell is the lower element of an active pair when its parity matches the phase.
    assign partner = (IsOdd == phase_odd) ? up : dn;
    assign swap[i] = is_sort && (IsOdd == phase_odd) && gt[i];

    sort_xcel_cell #(
      .W (W)
    ) u_cell (
      .clk (clk),
      .rst (~reset),
      .en  (en[i]),
      .sel (sel[i]),
      .in0 (shift_nb),
      .in1 (partner),
      .out (r[i]),
      .gt  (gt[i])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StLoad: begin
        if (in_fire) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_last) begin
            state_d = StSort;
            cnt_d   = '0;
          end
        end
      end
      StSort: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_last) begin
          state_d = StDrain;
          cnt_d   = '0;
        end
      end
      StDrain: begin
        if (out_fire) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_last) begin
            state_d = StLoad;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = StLoad;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    in_reset_q <= ~reset;
    if (!reset) begin
      state_q <= StLoad;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sort_xcel_batch.sv
// Directed and randomized batches checked against a queue-sort reference model.
module tb_sort_xcel_batch;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_val = 1'b0;
  logic        out_rdy = 1'b0;
  logic [31:0] in_msg = '0;
  logic        in_rdy, out_val, out_last;
  logic [31:0] out_msg;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sort_xcel_batch #(
    .NCELLS (N),
    .W      (32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_msg   (in_msg),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_msg  (out_msg),
    .out_last (out_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: out_rdy always 1; 1: pattern 1,0,0,1 repeating; 2: random.
  // abort_after >= 0 leaves the drain after that many words (block still in DRAIN).
  task automatic run_batch(input logic [31:0] w [N], input int mode, input int abort_after);
    logic [31:0] q[$];
    int idx;
    int budget;
    for (int k = 0; k < N; k++) begin
      in_val = 1'b1;
      in_msg = w[k];
      q.push_back(w[k]);
      chk("load_rdy", in_rdy, 1);
      chk("load_val", out_val, 0);
      step();
    end
    // Keep offering junk; it must never be accepted outside LOAD.
    in_msg = 32'd9;
    chk("sort_rdy", in_rdy, 0);
    chk("sort_val", out_val, 0);
    for (int j = 1; j < N; j++) begin
      step();
      chk("sort_rdy", in_rdy, 0);
      chk("sort_val", out_val, 0);
    end
    step();
    q.sort();
    idx = 0;
    budget = 0;
    while (idx < N && idx != abort_after && budget < 64) begin
      case (mode)
        0:       out_rdy = 1'b1;
        1:       out_rdy = ((budget % 4) == 0) || ((budget % 4) == 3);
        default: out_rdy = 1'($urandom_range(0, 1));
      endcase
      chk("drain_val", out_val, 1);
      chk("drain_msg", out_msg, q[idx]);
      chk("drain_last", out_last, (idx == N - 1));
      chk("drain_in_rdy", in_rdy, 0);
      if (out_rdy) idx++;
      budget++;
      step();
    end
    chk("drain_budget", 32'(budget < 64), 1);
    in_val  = 1'b0;
    out_rdy = 1'b0;
    if (abort_after < 0) begin
      chk("reload_rdy", in_rdy, 1);
      chk("idle_val", out_val, 0);
    end
  endtask

  initial begin
    logic [31:0] w [N];

    reset = 1'b0;
    repeat (3) step();
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_out_val", out_val, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_msg", out_msg, 0);
    reset = 1'b1;
    step();
    chk("rel_in_rdy", in_rdy, 1);
    chk("rel_out_val", out_val, 0);
    chk("rel_out_msg", out_msg, 0);

    w = '{32'd3, 32'd1, 32'd4, 32'd2};
    run_batch(w, 0, -1);
    w = '{32'd8, 32'd7, 32'd6, 32'd5};
    run_batch(w, 0, -1);
    w = '{32'd5, 32'd6, 32'd7, 32'd8};
    run_batch(w, 0, -1);
    w = '{32'd5, 32'd5, 32'd0, 32'd5};
    run_batch(w, 0, -1);
    w = '{32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'd1};
    run_batch(w, 0, -1);
    w = '{32'd11, 32'd2, 32'd40, 32'd7};
    run_batch(w, 1, -1);

    // Abort mid-drain after two words.
    w = '{32'd100, 32'd300, 32'd200, 32'd400};
    run_batch(w, 0, 2);
    reset = 1'b0;
    step();
    chk("abort_out_val", out_val, 0);
    chk("abort_out_msg", out_msg, 0);
    chk("abort_in_rdy", in_rdy, 0);
    chk("abort_out_last", out_last, 0);
    reset = 1'b1;
    step();
    chk("abort_rel_rdy", in_rdy, 1);
    w = '{32'd4, 32'd3, 32'd2, 32'd1};
    run_batch(w, 0, -1);

    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < N; k++) begin
        w[k] = (b % 2 == 0) ? $urandom() : 32'($urandom_range(0, 3));
      end
      run_batch(w, 2, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
